// File: rtl/euler_step_accumulator.sv
// Euler-step accumulator: adds rounded Q(2*FRAC) products into a saturating
// Q(FRAC) state for a programmed number of steps.
module euler_step_accumulator #(
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x0,
  input  logic [15:0] n_steps,
  input  logic [31:0] prod,
  input  logic        prod_valid,
  output logic        prod_ready,
  output logic [15:0] x_out,
  output logic        x_valid,
  output logic        busy,
  output logic        done,
  output logic        sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [32:0] RND = 33'sd1 <<< (FRAC - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] count_q, count_d;
  logic        sat_q, sat_d;
  logic        x_valid_q, x_valid_d;
  logic        done_q, done_d;

  logic signed [32:0] rounded;
  logic signed [32:0] scaled;
  logic signed [33:0] sum;
  logic [15:0]        x_next;
  logic               ovf;

  // Round-half-up scaling of the product and saturating add into the state.
  always_comb begin
    rounded = $signed({prod[31], prod}) + RND;
    scaled  = rounded >>> FRAC;
    sum     = $signed({{18{x_q[15]}}, x_q}) + $signed({scaled[32], scaled});
    ovf     = 1'b0;
    x_next  = sum[15:0];
    if (sum > 34'sd32767) begin
      x_next = 16'h7FFF;
      ovf    = 1'b1;
    end else if (sum < -34'sd32768) begin
      x_next = 16'h8000;
      ovf    = 1'b1;
    end
  end

  // Next-state and datapath update; only a valid product in RUN moves the state.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    count_d   = count_q;
    sat_d     = sat_q;
    x_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x0;
          count_d = n_steps;
          sat_d   = 1'b0;
          state_d = (n_steps != 16'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (prod_valid) begin
          x_d       = x_next;
          sat_d     = sat_q | ovf;
          count_d   = count_q - 16'd1;
          x_valid_d = 1'b1;
          if (count_q == 16'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign prod_ready = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign x_out      = x_q;
  assign x_valid    = x_valid_q;
  assign done       = done_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_euler_step_accumulator.sv
// Directed bench for euler_step_accumulator with hand-computed expectations.
module tb_euler_step_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x0;
  logic [15:0] n_steps;
  logic [31:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] x_out;
  logic        x_valid;
  logic        busy;
  logic        done;
  logic        sat;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  euler_step_accumulator #(.FRAC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x0         (x0),
    .n_steps    (n_steps),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] x_init, input logic [15:0] n);
    x0      = x_init;
    n_steps = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x0 = '0; n_steps = '0; prod = '0; prod_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_x_out", {16'h0, x_out}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_ready", {31'h0, prod_ready}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_sat", {31'h0, sat}, 32'h0);
    check_eq("rst_xvalid", {31'h0, x_valid}, 32'h0);

    // Reset wins over start
    start = 1'b1; x0 = 16'h1111; n_steps = 16'd2;
    tick();
    check_eq("rst_prio_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_prio_x", {16'h0, x_out}, 32'h0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Basic three-step accumulation
    start_run(16'h0100, 16'd3);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    check_eq("t1_ready", {31'h0, prod_ready}, 32'h1);
    check_eq("t1_x0", {16'h0, x_out}, 32'h0100);
    check_eq("t1_xv0", {31'h0, x_valid}, 32'h0);
    prod = 32'h0000_8000; prod_valid = 1'b1;
    tick();
    check_eq("t1_x1", {16'h0, x_out}, 32'h0180);
    check_eq("t1_xv1", {31'h0, x_valid}, 32'h1);
    tick();
    check_eq("t1_x2", {16'h0, x_out}, 32'h0200);
    check_eq("t1_xv2", {31'h0, x_valid}, 32'h1);
    check_eq("t1_done_early", {31'h0, done}, 32'h0);
    tick();
    prod_valid = 1'b0;
    check_eq("t1_x3", {16'h0, x_out}, 32'h0280);
    check_eq("t1_done", {31'h0, done}, 32'h1);
    check_eq("t1_busy_done", {31'h0, busy}, 32'h1);
    check_eq("t1_ready_done", {31'h0, prod_ready}, 32'h0);
    tick();
    check_eq("t1_done_off", {31'h0, done}, 32'h0);
    check_eq("t1_idle_busy", {31'h0, busy}, 32'h0);
    check_eq("t1_hold_x", {16'h0, x_out}, 32'h0280);
    check_eq("t1_sat", {31'h0, sat}, 32'h0);

    // Positive saturation
    start_run(16'h7F00, 16'd1);
    prod = 32'h0002_0000; prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    check_eq("t2_x_pos", {16'h0, x_out}, 32'h7FFF);
    check_eq("t2_sat_pos", {31'h0, sat}, 32'h1);
    check_eq("t2_done_pos", {31'h0, done}, 32'h1);
    tick();
    check_eq("t2_sat_hold", {31'h0, sat}, 32'h1);
    // Negative saturation; sat clears on start then sets again
    start_run(16'h8100, 16'd1);
    check_eq("t2_sat_clr", {31'h0, sat}, 32'h0);
    prod = 32'hFFFE_0000; prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    check_eq("t2_x_neg", {16'h0, x_out}, 32'h8000);
    check_eq("t2_sat_neg", {31'h0, sat}, 32'h1);
    tick();

    // Rounding and sign handling
    start_run(16'h0000, 16'd4);
    prod = 32'hFFFF_8000; prod_valid = 1'b1;
    tick();
    check_eq("t3_neg_half", {16'h0, x_out}, 32'hFF80);
    prod = 32'h0000_0080;
    tick();
    check_eq("t3_round_up", {16'h0, x_out}, 32'hFF81);
    prod = 32'h0000_007F;
    tick();
    check_eq("t3_round_down", {16'h0, x_out}, 32'hFF81);
    prod = 32'hFFFF_FF80;
    tick();
    prod_valid = 1'b0;
    check_eq("t3_neg_tie", {16'h0, x_out}, 32'hFF81);
    check_eq("t3_done", {31'h0, done}, 32'h1);
    check_eq("t3_sat", {31'h0, sat}, 32'h0);
    tick();

    // Zero-length run, with a product offered that must not be consumed
    prod = 32'h0001_0000; prod_valid = 1'b1;
    start_run(16'h1234, 16'd0);
    check_eq("t4_ready", {31'h0, prod_ready}, 32'h0);
    check_eq("t4_done", {31'h0, done}, 32'h1);
    check_eq("t4_x", {16'h0, x_out}, 32'h1234);
    check_eq("t4_xv", {31'h0, x_valid}, 32'h0);
    tick();
    prod_valid = 1'b0;
    check_eq("t4_done_off", {31'h0, done}, 32'h0);
    check_eq("t4_busy_off", {31'h0, busy}, 32'h0);
    check_eq("t4_x_hold", {16'h0, x_out}, 32'h1234);

    // Gapped valid, start ignored mid-run
    start_run(16'h0000, 16'd2);
    prod = 32'h0000_0100; prod_valid = 1'b1;
    tick();
    check_eq("t5_x1", {16'h0, x_out}, 32'h0001);
    prod_valid = 1'b0; start = 1'b1; x0 = 16'h5555; n_steps = 16'd9;
    tick();
    start = 1'b0;
    check_eq("t5_gap_x", {16'h0, x_out}, 32'h0001);
    check_eq("t5_gap_xv", {31'h0, x_valid}, 32'h0);
    check_eq("t5_gap_ready", {31'h0, prod_ready}, 32'h1);
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    check_eq("t5_x2", {16'h0, x_out}, 32'h0002);
    check_eq("t5_done", {31'h0, done}, 32'h1);
    tick();
    check_eq("t5_idle", {31'h0, busy}, 32'h0);

    // Reset in the middle of a run
    start_run(16'h0100, 16'd3);
    prod = 32'h0000_8000; prod_valid = 1'b1;
    tick();
    check_eq("t6_x1", {16'h0, x_out}, 32'h0180);
    rst = 1'b1;
    tick();
    check_eq("t6_x_rst", {16'h0, x_out}, 32'h0);
    check_eq("t6_sat_rst", {31'h0, sat}, 32'h0);
    check_eq("t6_ready_rst", {31'h0, prod_ready}, 32'h0);
    check_eq("t6_done_rst", {31'h0, done}, 32'h0);
    check_eq("t6_xv_rst", {31'h0, x_valid}, 32'h0);
    rst = 1'b0;
    tick();
    prod_valid = 1'b0;
    check_eq("t6_no_done", {31'h0, done}, 32'h0);
    check_eq("t6_idle", {31'h0, busy}, 32'h0);
    check_eq("t6_x_hold", {16'h0, x_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
